param_memory: RTL and testbench
===============================

PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per word (legal range 1..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: address bits; DEPTH = 2**ADDR_WIDTH words, a derived localparam and not overridable.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port ce, input, 1: chip enable; wren/rden are ignored when low.
REQ-006 SHALL have port wren, input, 1: write request.
REQ-007 SHALL have port rden, input, 1: read request.
REQ-008 SHALL have port addr, input, ADDR_WIDTH: word address.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH: write data.
REQ-010 SHALL have port rd_data, output, DATA_WIDTH: registered read data.
REQ-011 SHALL have port rd_valid, output, 1: one-cycle pulse marking rd_data valid.
REQ-012 SHALL have port ready, output, 1: high once initialisation is complete.
REQ-013 SHALL have port err, output, 1: one-cycle pulse flagging a rejected access.

Function
REQ-014 SHALL implement a two-state FSM, INIT and RUN; rst forces INIT with init counter = 0.
REQ-015 INIT: each cycle SHALL write init value to mem[counter] and increment counter; the write at counter = DEPTH-1 moves the FSM to RUN on the next edge (INIT lasts exactly DEPTH cycles).
REQ-016 ready SHALL be 0 in INIT and 1 in RUN; it is registered and goes high the cycle the FSM enters RUN.
REQ-017 In RUN, ce & rden at edge N SHALL load rd_data with mem[addr] and assert rd_valid for the cycle after edge N (latency 1); rd_data holds its value until the next read.
REQ-018 In RUN, ce & wren at edge N SHALL write wr_data to mem[addr]; a read of that address at edge N+1 returns the new data.
REQ-019 ce & rden & wren in the same cycle SHALL perform both: read-first, so rd_data returns the old contents and the write then commits.
REQ-020 With ce low, SHALL perform no access, keep rd_valid low and leave rd_data unchanged.
REQ-021 Any ce & (rden | wren) in INIT SHALL be discarded (no write, no rd_valid) and SHALL pulse err for one cycle.
REQ-022 err SHALL never assert in RUN.
REQ-023 Address space SHALL be fully decoded; no out-of-range condition exists.
REQ-024 The init counter SHALL be ADDR_WIDTH+1 bits wide so DEPTH-1 → terminal detection is wrap-free.

Reset
REQ-025 rst high at an edge SHALL set: rd_data = 0, rd_valid = 0, err = 0, ready = 0, FSM = INIT, counter = 0.
REQ-026 rst asserted mid-INIT SHALL restart initialisation from address 0.
REQ-027 rst asserted in RUN SHALL cancel any read issued on that edge (rd_valid stays 0) and re-run the full init.
REQ-028 Memory contents SHALL be defined only by init; rst itself does not clear the array except via INIT.

Configuration
REQ-029 Macro PARAM_MEMORY_INIT_PATTERN_EN SHALL select the init value.
REQ-030 With PARAM_MEMORY_INIT_PATTERN_EN defined, the init value SHALL be the word address zero-extended or truncated to DATA_WIDTH (mem[i] = i mod 2**DATA_WIDTH).
REQ-031 Without PARAM_MEMORY_INIT_PATTERN_EN, the init value SHALL be all zeros.
REQ-032 INIT timing (DEPTH cycles) SHALL be identical in both builds.

Verification (defaults DATA_WIDTH=8, ADDR_WIDTH=8)
REQ-033 rst 1 cycle, then idle → ready rises exactly 256 cycles after rst deasserts; err = 0 throughout.
REQ-034 Pattern build: after ready, read addr 0xA5 → next cycle rd_valid = 1, rd_data = 0xA5. Zero build: same read → rd_data = 0x00.
REQ-035 RUN: write 0x3C to addr 0x10, then read 0x10 on the next cycle → rd_data = 0x3C, rd_valid pulse of 1 cycle.
REQ-036 RUN: rden = wren = 1, addr 0x20, wr_data 0x77, old value 0x20 (pattern build) → rd_data = 0x20; a following read returns 0x77.
REQ-037 ce = 1, wren = 1 during INIT at cycle 5 → err pulses 1 cycle; after ready, that address still holds its init value.
REQ-038 rst asserted at INIT cycle 100 → ready rises 256 cycles after the second rst deasserts; rd_data = 0 and rd_valid = 0 during rst.

Source files
------------

// File: rtl/param_memory.sv
// param_memory: single-port synchronous memory with a self-initialisation phase.
//
// After reset the block spends exactly DEPTH cycles in INIT, writing an init
// value to every word, then moves to RUN where normal read/write accesses are
// served. Reads are registered (latency 1) and read-first when combined with a
// write to the same cycle. Accesses attempted during INIT are dropped and
// flagged with a one-cycle err pulse.
//
// Build option:
//   PARAM_MEMORY_INIT_PATTERN_EN  defined   -> mem[i] = i mod 2**DATA_WIDTH
//                                 undefined -> mem[i] = 0
// Both builds take the same number of cycles to initialise.

module param_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  ready,
    output logic                  err
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    // One extra bit so the counter can step past the last address without
    // wrapping back to zero.
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  init_cnt;
    logic [CNT_WIDTH-1:0]  init_cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  access_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] init_value;
    logic                  rd_en;
    logic                  err_next;

    assign access_req = ce & (rden | wren);

`ifdef PARAM_MEMORY_INIT_PATTERN_EN
    // The init word is the address being initialised, zero-extended when the
    // data word is wider than the address and truncated when it is narrower.
    localparam int EXT_WIDTH = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    logic [EXT_WIDTH-1:0] init_addr_ext;

    // Build the address-pattern init word from the current init address.
    always_comb begin
        init_addr_ext = EXT_WIDTH'(init_cnt[ADDR_WIDTH-1:0]);
        init_value    = init_addr_ext[DATA_WIDTH-1:0];
    end
`else
    assign init_value = '0;
`endif

    // Next-state and datapath control: INIT owns the write port, RUN hands it
    // to the user; reset suppresses every memory and read side effect.
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        mem_we        = 1'b0;
        mem_waddr     = addr;
        mem_wdata     = wr_data;
        rd_en         = 1'b0;
        err_next      = 1'b0;

        case (state)
            ST_INIT: begin
                mem_we        = 1'b1;
                mem_waddr     = init_cnt[ADDR_WIDTH-1:0];
                mem_wdata     = init_value;
                init_cnt_next = init_cnt + 1'b1;
                err_next      = access_req;
                if (init_cnt == CNT_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = ce & wren;
                rd_en  = ce & rden;
            end
            default: begin
                state_next    = ST_INIT;
                init_cnt_next = '0;
            end
        endcase

        if (rst) begin
            mem_we   = 1'b0;
            rd_en    = 1'b0;
            err_next = 1'b0;
        end
    end

    // State, init counter and status flags; ready follows the state that is
    // being entered so it rises on the same edge as the move to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
            ready    <= (state_next == ST_RUN);
            err      <= err_next;
        end
    end

    // Registered read port: old contents are returned when a write to the
    // same word happens on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[addr];
            end
        end
    end

    // Storage array write port, deliberately without reset so it maps onto
    // block RAM; contents only ever come from INIT or user writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: directed, self-checking bench for param_memory with
// default parameters. Expected values come from a vector table and from the
// init-value function below, which follows the build option
// PARAM_MEMORY_INIT_PATTERN_EN the same way the design is meant to.

module tb_param_memory;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          wren;
    logic          rden;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          ready;
    logic          err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       ce;
        logic       wren;
        logic       rden;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    param_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .wren    (wren),
        .rden    (rden),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .ready   (ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
`ifdef PARAM_MEMORY_INIT_PATTERN_EN
        return a;
`else
        return (a & 8'h00);
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic r,
                                 input logic [7:0] a, input logic [7:0] d);
        ce      = c;
        wren    = w;
        rden    = r;
        addr    = a;
        wr_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitReady(input string name, input int already, output int total);
        logic err_seen;
        err_seen = 1'b0;
        total    = already;
        while (!ready && total < 300) begin
            tick();
            total++;
            if (err) err_seen = 1'b1;
        end
        checkOutput({name, "_err_quiet"}, 32'(err_seen), 32'd0);
        checkOutput({name, "_ready_latency"}, 32'(total), 32'd256);
    endtask

    task automatic readCheck(input string name, input logic [7:0] a, input logic [7:0] exp);
        applyStimulus(1'b1, 1'b0, 1'b1, a, 8'h00);
        tick();
        checkOutput({name, "_valid"}, 32'(rd_valid), 32'd1);
        checkOutput({name, "_data"}, 32'(rd_data), 32'(exp));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b1, init_val(8'hA5)};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, init_val(8'hA5)};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h3C, 1'b0, init_val(8'hA5)};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'h3C};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h3C};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hFF, 1'b0, 8'h3C};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'h3C};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h20, 8'h77, 1'b1, init_val(8'h20)};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b1, 8'h77};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h81, 1'b0, 8'h77};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h81};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, init_val(8'h00)};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, init_val(8'h00)};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h5A};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h7F, 8'h00, 1'b1, init_val(8'h7F)};

        // Reset state and idle initialisation
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        waitReady("init1", 0, n);

        // Table-driven RUN accesses
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ce, vecs[i].wren, vecs[i].rden, vecs[i].addr, vecs[i].wdata);
            tick();
            checkOutput($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'd0);
        end

        // Reset in RUN cancels a read issued on the same edge
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
        rst = 1'b1;
        tick();
        checkOutput("runrst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("runrst_ready", 32'(ready), 32'd0);
        checkOutput("runrst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Write attempt during INIT cycle 5 must be dropped and flagged
        repeat (4) tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h02, 8'hEE);
        tick();
        checkOutput("init_wr_err_pulse", 32'(err), 32'd1);
        checkOutput("init_wr_ready", 32'(ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("init_wr_err_clear", 32'(err), 32'd0);
        waitReady("init2", 6, n);
        readCheck("dropped_wr", 8'h02, init_val(8'h02));
        readCheck("reinit_0x10", 8'h10, init_val(8'h10));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h40, 8'h33);
        tick();
        readCheck("wr_0x40", 8'h40, 8'h33);

        // Reset partway through INIT restarts the full initialisation
        rst = 1'b1;
        tick();
        checkOutput("rst3_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        repeat (99) tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, 8'h00);
        rst = 1'b1;
        tick();
        checkOutput("midinit_rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("midinit_rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("midinit_rst_ready", 32'(ready), 32'd0);
        checkOutput("midinit_rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        waitReady("init3", 0, n);
        readCheck("final_0xA5", 8'hA5, init_val(8'hA5));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
